mux_arb: RTL

Packet-level round-robin arbiter and sequencer for the 2:1 flit mux. It watches the flit type and valid of both mux inputs and drives the mux one-hot `sel`. It holds a grant for a whole packet (head through tail, wormhole style) and issues per-input acknowledges gated by downstream `iready`. It also maintains per-input completed-packet counters and a stall watchdog, and sits beside the mux in the router output stage.

---
 rtl/mux_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mux_arb.sv
`timescale 1ns/1ps
// mux_arb: packet-level round-robin arbiter for a 2:1 wormhole flit mux.
// Holds a grant from HEAD to TAIL, counts completed packets and breaks stalled locks with a watchdog.
module mux_arb #(
    parameter int TYPEW   = 2,
    parameter int CNTW    = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             iready,
    output logic [1:0]       sel,
    output logic             oack_0,
    output logic             oack_1,
    output logic             xfer,
    output logic             busy,
    output logic             err,
    output logic [CNTW-1:0]  pktcnt_0,
    output logic [CNTW-1:0]  pktcnt_1
);

    localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

    // The watchdog only ever holds 0..TIMEOUT-1: reaching TIMEOUT is the release itself.
    localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            first_q, first_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [1:0]      sel_q, sel_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] pktcnt_0_q, pktcnt_0_d;
    logic [CNTW-1:0] pktcnt_1_q, pktcnt_1_d;

    logic             req_0, req_1;
    logic             grant;
    logic             own_valid;
    logic [TYPEW-1:0] own_type;
    logic             xfer_c;

    assign req_0     = ivalid_0 && (itype_0 == T_HEAD);
    assign req_1     = ivalid_1 && (itype_1 == T_HEAD);
    assign own_valid = owner_q ? ivalid_1 : ivalid_0;
    assign own_type  = owner_q ? itype_1 : itype_0;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        first_d    = first_q;
        wdog_d     = wdog_q;
        sel_d      = sel_q;
        err_d      = 1'b0;
        pktcnt_0_d = pktcnt_0_q;
        pktcnt_1_d = pktcnt_1_q;
        grant      = 1'b0;
        xfer_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_0 || req_1) begin
                    grant   = (req_0 && req_1) ? ~last_q : req_1;
                    state_d = LOCK;
                    owner_d = grant;
                    sel_d   = grant ? 2'b10 : 2'b01;
                    first_d = 1'b1;
                    wdog_d  = '0;
                end
            end
            LOCK: begin
                xfer_c = own_valid && iready;
                if (xfer_c) begin
                    wdog_d  = '0;
                    first_d = 1'b0;
                    // Only the opening flit may legitimately be HEAD; a stray HEAD/NONE is flagged but forwarded.
                    if (!first_q && (own_type == T_HEAD || own_type == T_NONE)) begin
                        err_d = 1'b1;
                    end
                    if (own_type == T_TAIL) begin
                        state_d = IDLE;
                        sel_d   = 2'b00;
                        last_d  = owner_q;
                        if (owner_q) begin
                            pktcnt_1_d = pktcnt_1_q + CNTW'(1);
                        end else begin
                            pktcnt_0_d = pktcnt_0_q + CNTW'(1);
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    if (wdog_q == WD_LAST) begin
                        state_d = IDLE;
                        sel_d   = 2'b00;
                        err_d   = 1'b1;
                        last_d  = owner_q;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            first_q    <= 1'b0;
            wdog_q     <= '0;
            sel_q      <= 2'b00;
            err_q      <= 1'b0;
            pktcnt_0_q <= '0;
            pktcnt_1_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            first_q    <= first_d;
            wdog_q     <= wdog_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            pktcnt_0_q <= pktcnt_0_d;
            pktcnt_1_q <= pktcnt_1_d;
        end
    end

    // Acks are zero whenever IDLE, which reset forces asynchronously.
    assign xfer     = xfer_c;
    assign oack_0   = xfer_c && !owner_q;
    assign oack_1   = xfer_c && owner_q;
    assign sel      = sel_q;
    assign busy     = (state_q == LOCK);
    assign err      = err_q;
    assign pktcnt_0 = pktcnt_0_q;
    assign pktcnt_1 = pktcnt_1_q;

endmodule
